// File: rtl/alt_mem_ddrx_odt_rx_mon.sv
// DDR3 ODT receive monitor: decodes the phase-packed AFI ODT word into per-rank DRAM
// termination state aligned by ODTL, and checks pulse width and phase contiguity.
module alt_mem_ddrx_odt_rx_mon #(
  parameter int unsigned CFG_DWIDTH_RATIO          = 4,
  parameter int unsigned CFG_MEM_IF_ODT_WIDTH      = 2,
  parameter int unsigned CFG_PORT_WIDTH_CAS_WR_LAT = 4,
  parameter int unsigned CFG_PORT_WIDTH_ADD_LAT    = 3,
  parameter int unsigned CFG_MAX_ODTL              = 16,
  parameter int unsigned CFG_CNT_WIDTH             = 16
) (
  input  logic                                                      ctl_clk,
  input  logic                                                      ctl_reset_n,
  input  logic [CFG_PORT_WIDTH_CAS_WR_LAT-1:0]                      cfg_cas_wr_lat,
  input  logic [CFG_PORT_WIDTH_ADD_LAT-1:0]                         cfg_add_lat,
  input  logic                                                      cfg_enable,
  input  logic                                                      err_clr,
  input  logic [CFG_MEM_IF_ODT_WIDTH*(CFG_DWIDTH_RATIO/2)-1:0]      afi_odt,
  output logic [CFG_MEM_IF_ODT_WIDTH-1:0]                           rtt_active,
  output logic [CFG_MEM_IF_ODT_WIDTH*CFG_CNT_WIDTH-1:0]             odt_on_cnt,
  output logic [CFG_MEM_IF_ODT_WIDTH-1:0]                           err_short,
  output logic [CFG_MEM_IF_ODT_WIDTH-1:0]                           err_glitch
);

  localparam int P      = int'(CFG_DWIDTH_RATIO) / 2;
  localparam int W      = int'(CFG_MEM_IF_ODT_WIDTH);
  localparam int Cnt    = int'(CFG_CNT_WIDTH);
  localparam int Depth  = int'(CFG_MAX_ODTL);
  localparam int ShiftP = (P > 1) ? $clog2(P) : 0;
  localparam int LatW   = ((CFG_PORT_WIDTH_CAS_WR_LAT > CFG_PORT_WIDTH_ADD_LAT) ?
                           int'(CFG_PORT_WIDTH_CAS_WR_LAT) : int'(CFG_PORT_WIDTH_ADD_LAT)) + 1;
  localparam int TapW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int MaxTap = Depth - 1;
  localparam logic [2:0] MinW = 3'(8 / CFG_DWIDTH_RATIO);

  typedef enum logic {StOff, StOn} odt_st_e;

  odt_st_e          st_q       [W];
  logic [2:0]       width_q    [W];
  logic [Cnt-1:0]   cnt_q      [W];
  logic [Depth-1:0] line_q     [W];
  logic [W-1:0]     err_short_q;
  logic [W-1:0]     err_glitch_q;

  logic [W-1:0]     odt_any;
  logic [W-1:0]     glitch_set;
  logic [W-1:0]     short_set;
  logic [LatW-1:0]  lat_sum;
  logic [LatW-1:0]  odtl;
  logic [LatW-1:0]  d_full;
  logic [TapW-1:0]  tap_sel;

  function automatic logic [P-1:0] rank_phases(logic [W*P-1:0] bus, int r);
    logic [P-1:0] v;
    for (int p = 0; p < P; p++) v[p] = bus[p*W + r];
    return v;
  endfunction

  // True when the high phases form more than one run within the word.
  function automatic logic multi_run(logic [P-1:0] v);
    logic started, ended, bad;
    started = 1'b0;
    ended   = 1'b0;
    bad     = 1'b0;
    for (int p = 0; p < P; p++) begin
      if (v[p]) begin
        bad     = bad | ended;
        started = 1'b1;
      end else if (started) begin
        ended = 1'b1;
      end
    end
    return bad;
  endfunction

  // ODTL = CWL + AL - 2, floored at 0, converted to controller cycles and clamped.
  always_comb begin
    lat_sum = LatW'(cfg_cas_wr_lat) + LatW'(cfg_add_lat);
    odtl    = (lat_sum < LatW'(2)) ? '0 : lat_sum - LatW'(2);
    d_full  = odtl >> ShiftP;
    if (32'(d_full) > 32'(MaxTap)) tap_sel = TapW'(MaxTap);
    else                           tap_sel = TapW'(d_full);
  end

  always_comb begin
    odt_any    = '0;
    glitch_set = '0;
    short_set  = '0;
    for (int r = 0; r < W; r++) begin
      odt_any[r]    = cfg_enable & (|rank_phases(afi_odt, r));
      glitch_set[r] = cfg_enable & multi_run(rank_phases(afi_odt, r));
      short_set[r]  = cfg_enable && (st_q[r] == StOn) && !(|rank_phases(afi_odt, r)) &&
                      (width_q[r] < MinW);
    end
  end

  always_ff @(posedge ctl_clk) begin
    if (!ctl_reset_n) begin
      for (int r = 0; r < W; r++) begin
        st_q[r]    <= StOff;
        width_q[r] <= '0;
        cnt_q[r]   <= '0;
        line_q[r]  <= '0;
      end
      err_short_q  <= '0;
      err_glitch_q <= '0;
    end else begin
      for (int r = 0; r < W; r++) begin
        // Tap 0 is the input register, so D=0 still gives one cycle of latency.
        line_q[r] <= {line_q[r][Depth-2:0], odt_any[r]};
        if (!cfg_enable) begin
          st_q[r]    <= StOff;
          width_q[r] <= '0;
        end else begin
          unique case (st_q[r])
            StOff: begin
              if (odt_any[r]) begin
                st_q[r]    <= StOn;
                width_q[r] <= 3'd1;
                if (cnt_q[r] != '1) cnt_q[r] <= cnt_q[r] + Cnt'(1);
              end
            end
            StOn: begin
              if (odt_any[r]) begin
                if (width_q[r] < MinW) width_q[r] <= width_q[r] + 3'd1;
              end else begin
                st_q[r]    <= StOff;
                width_q[r] <= '0;
              end
            end
            default: st_q[r] <= StOff;
          endcase
        end
      end
      err_short_q  <= (err_short_q  & ~{W{err_clr}}) | short_set;
      err_glitch_q <= (err_glitch_q & ~{W{err_clr}}) | glitch_set;
    end
  end

  always_comb begin
    rtt_active = '0;
    odt_on_cnt = '0;
    for (int r = 0; r < W; r++) begin
      rtt_active[r]               = line_q[r][tap_sel];
      odt_on_cnt[r*Cnt +: Cnt]    = cnt_q[r];
    end
  end

  assign err_short  = err_short_q;
  assign err_glitch = err_glitch_q;

endmodule

// File: tb/tb_alt_mem_ddrx_odt_rx_mon.sv
// Bench for alt_mem_ddrx_odt_rx_mon: three configurations (ratio 4, ratio 8 with 3-bit
// counters, ratio 2) checked every cycle against a cycle-log model plus literal expectations.
module tb_alt_mem_ddrx_odt_rx_mon;

  localparam int NC = 3;

  function automatic int ratio_of(int i);
    case (i)
      0:       return 4;
      1:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int cntw_of(int i);
    return (i == 1) ? 3 : 16;
  endfunction

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cwl   = 4'd6;
  logic [2:0] al    = 3'd0;
  logic       en    = 1'b1;
  logic       clr   = 1'b0;
  logic [15:0] afi     [NC];
  logic [1:0]  rtt_act [NC];
  logic [1:0]  es_act  [NC];
  logic [1:0]  eg_act  [NC];
  logic [15:0] cnt_act [NC][2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < NC; i++) begin : g_dut
    localparam int R  = ratio_of(i);
    localparam int CW = cntw_of(i);
    localparam int PW = 2 * (R / 2);
    logic [2*CW-1:0] cnt_flat;
    alt_mem_ddrx_odt_rx_mon #(
      .CFG_DWIDTH_RATIO         (R),
      .CFG_MEM_IF_ODT_WIDTH     (2),
      .CFG_PORT_WIDTH_CAS_WR_LAT(4),
      .CFG_PORT_WIDTH_ADD_LAT   (3),
      .CFG_MAX_ODTL             (16),
      .CFG_CNT_WIDTH            (CW)
    ) u_dut (
      .ctl_clk       (clk),
      .ctl_reset_n   (rst_n),
      .cfg_cas_wr_lat(cwl),
      .cfg_add_lat   (al),
      .cfg_enable    (en),
      .err_clr       (clr),
      .afi_odt       (afi[i][PW-1:0]),
      .rtt_active    (rtt_act[i]),
      .odt_on_cnt    (cnt_flat),
      .err_short     (es_act[i]),
      .err_glitch    (eg_act[i])
    );
    assign cnt_act[i][0] = 16'(cnt_flat[CW-1:0]);
    assign cnt_act[i][1] = 16'(cnt_flat[2*CW-1:CW]);
  end

  // Model: per-cycle log of gated rank activity and resets, plus run/event bookkeeping.
  bit any_log [NC][2][4096];
  bit rst_log [4096];
  int run_m   [NC][2];
  int cnt_m   [NC][2];
  bit es_m    [NC][2];
  bit eg_m    [NC][2];

  task automatic check(string name, int c, longint got, longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc %0d: got %0h want %0h", name, c, cyc, got, want);
    end
  endtask

  function automatic int exp_tap(int p);
    int odtl;
    odtl = int'(cwl) + int'(al) - 2;
    if (odtl < 0) odtl = 0;
    odtl = odtl / p;
    return (odtl > 15) ? 15 : odtl;
  endfunction

  function automatic bit phase_bit(int c, int r, int p);
    return afi[c][p*2 + r];
  endfunction

  always @(negedge clk) begin
    int n, m, np, minw, starts, cmax;
    bit v, any, set_s, set_g;
    logic [1:0] er, ees, eeg;
    n = cyc;
    if (n < 4000) begin
      for (int c = 0; c < NC; c++) begin
        np   = ratio_of(c) / 2;
        cmax = (1 << cntw_of(c)) - 1;
        for (int r = 0; r < 2; r++) begin
          m = n - 1 - exp_tap(np);
          v = 1'b0;
          if (m >= 0) begin
            v = any_log[c][r][m];
            for (int k = m; k < n; k++) if (rst_log[k]) v = 1'b0;
          end
          er[r]  = v;
          ees[r] = es_m[c][r];
          eeg[r] = eg_m[c][r];
          check("odt_on_cnt", c, cnt_act[c][r], (cnt_m[c][r] > cmax) ? cmax : cnt_m[c][r]);
        end
        check("rtt_active", c, rtt_act[c], er);
        check("err_short", c, es_act[c], ees);
        check("err_glitch", c, eg_act[c], eeg);
      end
      // Fold this cycle's inputs into the model.
      rst_log[n] = !rst_n;
      for (int c = 0; c < NC; c++) begin
        np   = ratio_of(c) / 2;
        minw = 8 / ratio_of(c);
        for (int r = 0; r < 2; r++) begin
          any    = 1'b0;
          starts = 0;
          for (int p = 0; p < np; p++) begin
            if (phase_bit(c, r, p)) begin
              any = 1'b1;
              if (p == 0 || !phase_bit(c, r, p - 1)) starts++;
            end
          end
          any_log[c][r][n] = en & any;
          if (!rst_n) begin
            run_m[c][r] = 0;
            cnt_m[c][r] = 0;
            es_m[c][r]  = 1'b0;
            eg_m[c][r]  = 1'b0;
          end else begin
            set_s = 1'b0;
            set_g = 1'b0;
            if (en) begin
              set_g = (starts > 1);
              if (any) begin
                if (run_m[c][r] == 0) cnt_m[c][r]++;
                run_m[c][r]++;
              end else begin
                if (run_m[c][r] > 0 && run_m[c][r] < minw) set_s = 1'b1;
                run_m[c][r] = 0;
              end
            end else begin
              run_m[c][r] = 0;
            end
            if (clr) begin
              es_m[c][r] = 1'b0;
              eg_m[c][r] = 1'b0;
            end
            es_m[c][r] = es_m[c][r] | set_s;
            eg_m[c][r] = eg_m[c][r] | set_g;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) afi[i] = '0;
    rst_log[0] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Delay alignment: ratio 4, CWL=6 -> D=2.
    for (int k = 0; k < 8; k++) begin
      afi[0] = (k < 3) ? 16'h5 : 16'h0;
      @(negedge clk);
      check("lit_delay_rtt0", 0, rtt_act[0][0], (k >= 3 && k <= 5) ? 1 : 0);
      check("lit_delay_rtt1", 0, rtt_act[0][1], 0);
      tick();
    end
    @(negedge clk);
    check("lit_delay_cnt0", 0, cnt_act[0][0], 1);
    check("lit_delay_cnt1", 0, cnt_act[0][1], 0);
    repeat (4) tick();

    // Short pulse on rank 1 (MIN=2), then clear, then a legal 2-cycle pulse.
    for (int k = 0; k < 4; k++) begin
      afi[0] = (k == 0) ? 16'h8 : 16'h0;
      @(negedge clk);
      check("lit_short_set", 0, es_act[0], (k >= 2) ? 2 : 0);
      tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("lit_short_clr", 0, es_act[0], 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      afi[0] = (k < 2) ? 16'h8 : 16'h0;
      tick();
    end
    @(negedge clk);
    check("lit_short_ok", 0, es_act[0], 0);
    tick();

    // Glitch on ratio 8: rank 1 phases 1,0,1,0 then 0,1,1,1.
    for (int k = 0; k < 3; k++) begin
      afi[1] = (k == 0) ? 16'h22 : 16'h0;
      @(negedge clk);
      check("lit_glitch_set", 1, eg_act[1], (k >= 1) ? 2 : 0);
      tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      afi[1] = (k == 0) ? 16'hA8 : 16'h0;
      @(negedge clk);
      check("lit_glitch_ok", 1, eg_act[1], 0);
      tick();
    end

    // Underflow: CWL=1 -> D=0, one-cycle latency.
    cwl = 4'd1;
    al  = 3'd0;
    tick();
    for (int k = 0; k < 4; k++) begin
      afi[0] = (k == 0) ? 16'h1 : 16'h0;
      @(negedge clk);
      check("lit_underflow", 0, rtt_act[0][0], (k == 1) ? 1 : 0);
      tick();
    end
    // Clamp: CWL=15, AL=7, ratio 2 -> D=15, 16-cycle latency.
    cwl = 4'd15;
    al  = 3'd7;
    tick();
    for (int k = 0; k < 18; k++) begin
      afi[2] = (k == 0) ? 16'h1 : 16'h0;
      @(negedge clk);
      check("lit_clamp", 2, rtt_act[2][0], (k == 16) ? 1 : 0);
      tick();
    end

    // Counter saturation: 9 separated pulses on a 3-bit counter.
    for (int k = 0; k < 18; k++) begin
      afi[1] = (k % 2 == 0) ? 16'h1 : 16'h0;
      tick();
    end
    @(negedge clk);
    check("lit_saturate", 1, cnt_act[1][0], 7);

    // Reset mid-pulse with D=3: nothing stale emerges.
    cwl = 4'd8;
    al  = 3'd0;
    repeat (20) tick();
    for (int k = 0; k < 9; k++) begin
      afi[0] = (k < 3) ? 16'h5 : 16'h0;
      rst_n  = (k == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k >= 3) check("lit_rst_rtt", 0, rtt_act[0][0], 0);
      if (k == 3) begin
        check("lit_rst_cnt", 0, cnt_act[0][0], 0);
        check("lit_rst_short", 0, es_act[0], 0);
      end
      tick();
    end

    // Disable mid-pulse: no short error, counter holds.
    for (int k = 0; k < 7; k++) begin
      afi[0] = (k < 3) ? 16'h1 : 16'h0;
      en     = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
      tick();
    end
    @(negedge clk);
    check("lit_dis_short", 0, es_act[0], 0);
    check("lit_dis_cnt", 0, cnt_act[0][0], 1);
    en = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
